// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares the single unified instruction/data memory between the
//             CPU port and a DMA/loader port. Round-robin arbitration, one
//             transaction in flight, fixed read latency of MEM_LAT cycles.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W   address width
//    DATA_W   data width
//    MEM_LAT  cycles mem_read is held before mem_rdata is valid (1..15)
//  Ports
//    clk, reset                  clock (rising edge), async active-low reset
//    cpu_req/we/addr/wdata       CPU request (held until cpu_ack)
//    cpu_rdata, cpu_ack          CPU read data (held), one-cycle completion
//    dma_*                       same as cpu_* for the DMA port
//    mem_addr/wdata/read/write   registered memory strobes (0 when idle)
//    mem_rdata                   memory read data
//    busy                        high in every state except IDLE
//  Optional build macro
//    MEM_ARB_PERF_EN  adds saturating 16-bit counters cpu_gnt_cnt,
//                     dma_gnt_cnt and conflict_cnt
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [15:0]       cpu_gnt_cnt,
    output logic [15:0]       dma_gnt_cnt,
    output logic [15:0]       conflict_cnt,
`endif
    output logic              busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RD    = 2'd1;
    localparam logic [1:0] c_ST_WR    = 2'd2;
    localparam logic [1:0] c_ST_ACK   = 2'd3;

    localparam logic       c_OWN_CPU  = 1'b0;
    localparam logic       c_OWN_DMA  = 1'b1;

    // 4 bits covers the full legal MEM_LAT range of 1..15.
    localparam logic [3:0] c_CNT_LAST = 4'(MEM_LAT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;

    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_last_gnt;

    logic              w_grant;
    logic              w_gnt_dma;
    logic              w_gnt_we;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_wdata;
    logic              w_capture;

    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;
    logic              r_cpu_ack;
    logic              r_dma_ack;
    logic              r_busy;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester wins; on a tie the port that was not
    // granted last wins. Only evaluated in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_dma   = dma_req && (!cpu_req || (r_last_gnt == c_OWN_CPU));
        w_gnt_we    = w_gnt_dma ? dma_we    : cpu_we;
        w_gnt_addr  = w_gnt_dma ? dma_addr  : cpu_addr;
        w_gnt_wdata = w_gnt_dma ? dma_wdata : cpu_wdata;
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    w_grant     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_gnt_we ? c_ST_WR : c_ST_RD;
                end
            end
            c_ST_RD: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_ACK;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            c_ST_WR:  w_state_nxt = c_ST_ACK;
            c_ST_ACK: w_state_nxt = c_ST_IDLE;
            default:  w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and registered outputs. Outputs are computed from the
    // next state so they line up with the state they belong to while
    // still coming straight out of flops.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner     <= c_OWN_CPU;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_last_gnt  <= c_OWN_DMA;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_dma_ack   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_grant) begin
                r_owner    <= w_gnt_dma;
                r_we       <= w_gnt_we;
                r_addr     <= w_gnt_addr;
                r_wdata    <= w_gnt_wdata;
                r_last_gnt <= w_gnt_dma;
            end

            r_mem_read  <= (w_state_nxt == c_ST_RD);
            r_mem_write <= (w_state_nxt == c_ST_WR);
            r_busy      <= (w_state_nxt != c_ST_IDLE);

            if ((w_state_nxt == c_ST_RD) || (w_state_nxt == c_ST_WR)) begin
                r_mem_addr <= w_grant ? w_gnt_addr : r_addr;
            end else begin
                r_mem_addr <= '0;
            end

            if (w_state_nxt == c_ST_WR) begin
                r_mem_wdata <= w_grant ? w_gnt_wdata : r_wdata;
            end else begin
                r_mem_wdata <= '0;
            end

            // Owner is already latched by the time ACK is entered.
            r_cpu_ack <= (w_state_nxt == c_ST_ACK) && (r_owner == c_OWN_CPU);
            r_dma_ack <= (w_state_nxt == c_ST_ACK) && (r_owner == c_OWN_DMA);

            // Read data is only sampled at the end of the final RD cycle;
            // earlier mem_rdata activity is ignored.
            if (w_capture) begin
                if (r_owner == c_OWN_DMA) begin
                    r_dma_rdata <= mem_rdata;
                end else begin
                    r_cpu_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign dma_ack   = r_dma_ack;
    assign busy      = r_busy;

`ifdef MEM_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [15:0] r_cpu_gnt_cnt;
    logic [15:0] r_dma_gnt_cnt;
    logic [15:0] r_conflict_cnt;
    logic        w_conflict;

    assign w_conflict = (r_state == c_ST_IDLE) && cpu_req && dma_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_gnt_cnt  <= '0;
            r_dma_gnt_cnt  <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_grant && !w_gnt_dma && (r_cpu_gnt_cnt != 16'hFFFF)) begin
                r_cpu_gnt_cnt <= r_cpu_gnt_cnt + 16'd1;
            end
            if (w_grant && w_gnt_dma && (r_dma_gnt_cnt != 16'hFFFF)) begin
                r_dma_gnt_cnt <= r_dma_gnt_cnt + 16'd1;
            end
            if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign cpu_gnt_cnt  = r_cpu_gnt_cnt;
    assign dma_gnt_cnt  = r_dma_gnt_cnt;
    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multi-cycle CPU between two requesters: the CPU (IF/MAR/MAW accesses) and a DMA/loader port.
- Round-robin arbitration; one transaction in flight; fixed, parameterised memory read latency.
- The CPU controller holds its current state while cpu_ack is low.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- MEM_LAT, 1, cycles mem_read is held before mem_rdata is valid (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; valid while cpu_ack is high.
- cpu_ack  out  1  one-cycle completion pulse.
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: same as the cpu_* ports, for the DMA port.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; last_gnt = DMA, so the CPU wins the first tie.
  - All outputs 0; latency counter 0.
- States: IDLE, RD, WR, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Only one of cpu_req / dma_req high: grant that port.
  - Both high: grant the port not equal to last_gnt.
  - On grant: latch owner, we, addr, wdata into internal registers and update last_gnt.
  - Next state: RD if we=0, WR if we=1. A grant costs one cycle; IDLE drives no memory strobes.
- RD:
  - mem_read = 1 and mem_addr = latched addr for exactly MEM_LAT cycles.
  - The counter counts 0..MEM_LAT-1.
  - At the rising edge ending the last cycle, capture mem_rdata into the owner's rdata register, then go to ACK.
- WR:
  - mem_write = 1 for exactly 1 cycle, with mem_addr and mem_wdata from the latched values; then go to ACK.
- ACK:
  - The owner's ack = 1 for exactly one cycle; the other port's ack stays 0.
  - Next state: IDLE, so back-to-back transactions are separated by one IDLE cycle.
- Latency from grant cycle to ack: read = MEM_LAT + 2 cycles; write = 3 cycles.
- Read data: cpu_rdata / dma_rdata holds its last captured value until the next read by the same port completes. It is not cleared on ack.
- Registered outputs: mem_* are registered outputs, with no combinational path from req to mem_*. The mem_* outputs are 0 in IDLE and ACK.
- Request dropped mid-transaction (protocol violation): the transaction still completes and ack still pulses. It is not aborted.
- Request held high after ack: treated as a new request in the following IDLE cycle.
- Request changes while not owner: ignored until the next IDLE arbitration.
- Fairness: with both requests held continuously, grants alternate CPU, DMA, CPU, ...
- Reset asserted mid-transaction: immediate return to reset values. A partially asserted mem_write is dropped and no ack is issued.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined:
  - Adds outputs cpu_gnt_cnt (16 bit), dma_gnt_cnt (16 bit) and conflict_cnt (16 bit).
  - Each grant counter increments in the cycle its port is granted.
  - conflict_cnt increments in any IDLE cycle where both requests are high.
  - Counters saturate at 16'hFFFF and clear on reset.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- CPU read, MEM_LAT=1:
  - Stimulus: cpu_req=1, cpu_we=0, cpu_addr=0x0000_0040, memory returns 0xDEADBEEF.
  - Required: mem_read high 1 cycle with mem_addr=0x40; cpu_ack pulses 3 cycles after grant; cpu_rdata=0xDEADBEEF; dma_ack stays 0.
- DMA write:
  - Stimulus: dma_req=1, dma_we=1, addr=0x100, wdata=0x12345678.
  - Required: exactly one mem_write cycle with those values; dma_ack pulses once; mem_read never asserts.
- Simultaneous requests from reset:
  - Stimulus: both reqs held high for 4 transactions.
  - Required: grant order CPU, DMA, CPU, DMA; each ack a single pulse; conflict_cnt=4 when MEM_ARB_PERF_EN is defined.
- MEM_LAT=3 read:
  - Required: mem_read high exactly 3 consecutive cycles; ack 5 cycles after grant; data captured on the 3rd cycle only (mem_rdata toggled beforehand must be ignored).
- Reset mid-write:
  - Stimulus: reset low during WR.
  - Required: mem_write, busy and acks drop to 0 asynchronously; after release, state is IDLE and the CPU wins the first tie.
- Request dropped:
  - Stimulus: cpu_req deasserted during RD.
  - Required: access completes and cpu_ack still pulses once; DMA is then granted normally.
